// File: rtl/root_square_recon.sv
// Rebuilds a sample from its integer square root and remainder.
// A shift-add multiplier forms root*root, then the remainder is added with saturation.
module root_square_recon #(
    parameter int DW = 8,
    parameter int RW = DW / 2
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [RW-1:0] Root_i,
    input  logic [RW:0]   Rem_i,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [DW-1:0] Square_o,
    output logic          Err_o,
    output logic          Busy_o
);

    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   acc_q, acc_d;
    logic [RW-1:0] root_q, root_d;
    logic [RW:0]   rem_q, rem_d;
    logic [DW-1:0] sq_q, sq_d;
    logic          err_q, err_d;

    logic          last_mul;
    logic [DW:0]   partial;
    logic [DW:0]   acc_sum;
    logic          rem_bad;

    assign last_mul = (cnt_q == CW'(RW - 1));
    assign partial  = (DW + 1)'(root_q) << cnt_q;
    assign acc_sum  = acc_q + (DW + 1)'(rem_q);
    assign rem_bad  = (rem_q > {root_q, 1'b0});

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (In_valid) state_d = MUL;
            MUL:  if (last_mul) state_d = ADD;
            ADD:  state_d = DONE;
            DONE: if (Out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and result registers
    always_comb begin
        In_ready  = (state_q == IDLE);
        Out_valid = (state_q == DONE);
        Busy_o    = (state_q != IDLE);
        Square_o  = sq_q;
        Err_o     = err_q;
    end

    // Datapath next values: capture, shift-add, remainder add with saturation
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        root_d = root_q;
        rem_d  = rem_q;
        sq_d   = sq_q;
        err_d  = err_q;
        unique case (state_q)
            IDLE: begin
                if (In_valid) begin
                    root_d = Root_i;
                    rem_d  = Rem_i;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            MUL: begin
                if (root_q[cnt_q]) acc_d = acc_q + partial;
                cnt_d = cnt_q + CW'(1);
            end
            ADD: begin
                acc_d = acc_sum;
                err_d = rem_bad | acc_sum[DW];
                sq_d  = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            sq_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            root_q <= root_d;
            rem_q  <= rem_d;
            sq_q   <= sq_d;
            err_q  <= err_d;
        end
    end

endmodule
